// File: rtl/ay_env_multi.sv
// ay_env_multi: NCH independent AY/YM-style envelope generators sharing one
// prescaled envelope time base (env_clk_tick). Each channel holds its own
// shape, period, step counter, level, direction and hold flag.
// Optional feature macro: AY_ENV_MULTI_DONE_EN adds the per-channel 'done'
// port, which pulses for one clk when a channel enters hold by progression.
module ay_env_multi #(
  parameter int NCH      = 3,
  parameter int OUT_W    = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    env_clk_tick,
  input  logic                    wr_tick,
  input  logic [2:0]              wr_ch,
  input  logic [3:0]              wr_shape,
  input  logic [PERIOD_W-1:0]     wr_period,
`ifdef AY_ENV_MULTI_DONE_EN
  output logic [NCH-1:0]          done,
`endif
  output logic [NCH*OUT_W-1:0]    out
);

  localparam logic [OUT_W-1:0] LVL_MAX = '1;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PERIOD_W-1:0] period_reg;
      logic [PERIOD_W-1:0] cnt_reg;
      logic [PERIOD_W-1:0] cnt_next;
      logic [PERIOD_W-1:0] last_cnt;
      logic [3:0]          shape_reg;   // {cont, attack, alt, hold}
      logic [OUT_W-1:0]    level_reg;
      logic [OUT_W-1:0]    level_next;
      logic [OUT_W-1:0]    terminal;
      logic                dir_reg;     // 1 = counting up
      logic                dir_next;
      logic                held_reg;
      logic                held_next;
      logic                wr_hit;

      // Writes to channel indices that do not exist never match any channel.
      assign wr_hit   = wr_tick && (wr_ch == 3'(gi));
      // A zero period behaves like a period of one tick.
      assign last_cnt = (period_reg == '0) ? '0 : period_reg - 1'b1;
      assign terminal = dir_reg ? LVL_MAX : '0;

      // Next-state: a write restarts the channel and masks a coincident tick;
      // otherwise a tick advances the step counter and, on wrap, the level.
      always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        dir_next   = dir_reg;
        held_next  = held_reg;
        if (wr_hit) begin
          cnt_next   = '0;
          held_next  = 1'b0;
          dir_next   = wr_shape[2];
          level_next = wr_shape[2] ? '0 : LVL_MAX;
        end else if (env_clk_tick && !held_reg) begin
          if (cnt_reg == last_cnt) begin
            cnt_next = '0;
            if (level_reg != terminal) begin
              level_next = dir_reg ? level_reg + 1'b1 : level_reg - 1'b1;
            end else if (!shape_reg[3]) begin
              // One-shot shapes always park at zero.
              level_next = '0;
              held_next  = 1'b1;
            end else if (shape_reg[0]) begin
              // Continuous + hold: park at terminal, or its complement if alt.
              level_next = shape_reg[1] ? ~terminal : terminal;
              held_next  = 1'b1;
            end else if (shape_reg[1]) begin
              // Triangle: reverse and move away from the terminal this step.
              dir_next   = ~dir_reg;
              level_next = dir_reg ? level_reg - 1'b1 : level_reg + 1'b1;
            end else begin
              // Sawtooth: jump back to the starting level.
              level_next = dir_reg ? '0 : LVL_MAX;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      // Channel state registers; reset parks every channel in hold at zero.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          period_reg <= '0;
          shape_reg  <= '0;
          cnt_reg    <= '0;
          level_reg  <= '0;
          dir_reg    <= 1'b0;
          held_reg   <= 1'b1;
        end else begin
          if (wr_hit) begin
            period_reg <= wr_period;
            shape_reg  <= wr_shape;
          end
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          dir_reg   <= dir_next;
          held_reg  <= held_next;
        end
      end

      assign out[gi*OUT_W +: OUT_W] = level_reg;

`ifdef AY_ENV_MULTI_DONE_EN
      logic done_reg;

      // Hold entry can only come from progression: writes clear held and
      // reset bypasses held_next entirely.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          done_reg <= 1'b0;
        end else begin
          done_reg <= held_next && !held_reg;
        end
      end

      assign done[gi] = done_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ay_env_multi.sv
// tb_ay_env_multi: table-driven checks of ay_env_multi (NCH=3, OUT_W=4) plus
// hand-written sequences for triangle, hold shapes and an OUT_W=5 instance.
`timescale 1ns/1ps
module tb_ay_env_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        env_clk_tick;
  logic        wr_tick;
  logic [2:0]  wr_ch;
  logic [3:0]  wr_shape;
  logic [15:0] wr_period;
  logic [11:0] out4;
  logic [14:0] out5;
`ifdef AY_ENV_MULTI_DONE_EN
  logic [2:0]  done4;
  logic [2:0]  done5;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ay_env_multi #(.NCH(3), .OUT_W(4), .PERIOD_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .env_clk_tick (env_clk_tick),
    .wr_tick      (wr_tick),
    .wr_ch        (wr_ch),
    .wr_shape     (wr_shape),
    .wr_period    (wr_period),
`ifdef AY_ENV_MULTI_DONE_EN
    .done         (done4),
`endif
    .out          (out4)
  );

  ay_env_multi #(.NCH(3), .OUT_W(5), .PERIOD_W(16)) dut5 (
    .clk          (clk),
    .reset_n      (reset_n),
    .env_clk_tick (env_clk_tick),
    .wr_tick      (wr_tick),
    .wr_ch        (wr_ch),
    .wr_shape     (wr_shape),
    .wr_period    (wr_period),
`ifdef AY_ENV_MULTI_DONE_EN
    .done         (done5),
`endif
    .out          (out5)
  );

  typedef struct {
    logic        rst_n;
    logic        tick;
    logic        wr;
    logic [2:0]  ch;
    logic [3:0]  shape;
    logic [15:0] period;
    int          n;
    logic [11:0] exp_out;
    string       name;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s act=%0h exp=%0h", name, act, exp);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock: inputs set beforehand are sampled at this edge; outputs are
  // read 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_n      = 1'b1;
    env_clk_tick = 1'b0;
    wr_tick      = 1'b0;
    wr_ch        = 3'd0;
    wr_shape     = 4'd0;
    wr_period    = 16'd0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    cyc();
    cyc();
    idle();
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [3:0] shape,
                          input logic [15:0] period, input logic tick);
    wr_tick      = 1'b1;
    wr_ch        = ch;
    wr_shape     = shape;
    wr_period    = period;
    env_clk_tick = tick;
    cyc();
    idle();
  endtask

  task automatic ticks(input int n);
    env_clk_tick = 1'b1;
    repeat (n) cyc();
    env_clk_tick = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst_n, input logic tick, input logic wr,
                              input logic [2:0] ch, input logic [3:0] shape,
                              input logic [15:0] period, input int n,
                              input logic [11:0] exp_out, input string name);
    vec_t v;
    v.rst_n = rst_n; v.tick = tick; v.wr = wr; v.ch = ch; v.shape = shape;
    v.period = period; v.n = n; v.exp_out = exp_out; v.name = name;
    return v;
  endfunction

  initial begin
    int tri_exp;
    int lvl0;
    int lvl1;

    idle();
    reset_n = 1'b0;

    //            rst tick wr  ch    shape    period  n    exp      name
    vecs[0]  = mk(0,  0,   0,  3'd0, 4'b0000, 16'd0,  2,   12'h000, "reset");
    vecs[1]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  5,   12'h000, "idle_ticks");
    vecs[2]  = mk(1,  0,   1,  3'd0, 4'b0000, 16'd10, 1,   12'h00F, "ch0_load");
    vecs[3]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  9,   12'h00F, "ch0_pre_step");
    vecs[4]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  1,   12'h00E, "ch0_first_step");
    vecs[5]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  140, 12'h000, "ch0_at_zero");
    vecs[6]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  60,  12'h000, "ch0_held");
    vecs[7]  = mk(1,  0,   1,  3'd1, 4'b1000, 16'd1,  1,   12'h0F0, "ch1_load");
    vecs[8]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  1,   12'h0E0, "ch1_step");
    vecs[9]  = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  14,  12'h000, "ch1_bottom");
    vecs[10] = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  1,   12'h0F0, "ch1_wrap");
    vecs[11] = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  16,  12'h0F0, "ch1_cycle");
    vecs[12] = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  3,   12'h0C0, "ch1_mid");
    vecs[13] = mk(1,  0,   1,  3'd5, 4'b1100, 16'd1,  1,   12'h0C0, "wr_ch5_ignored");
    vecs[14] = mk(1,  0,   1,  3'd3, 4'b1100, 16'd1,  1,   12'h0C0, "wr_ch3_ignored");
    vecs[15] = mk(0,  1,   0,  3'd0, 4'b0000, 16'd0,  1,   12'h000, "reset_mid");
    vecs[16] = mk(1,  1,   0,  3'd0, 4'b0000, 16'd0,  20,  12'h000, "post_reset_idle");

    for (int i = 0; i < 17; i++) begin
      reset_n      = vecs[i].rst_n;
      env_clk_tick = vecs[i].tick;
      wr_tick      = vecs[i].wr;
      wr_ch        = vecs[i].ch;
      wr_shape     = vecs[i].shape;
      wr_period    = vecs[i].period;
      repeat (vecs[i].n) cyc();
      idle();
      check(vecs[i].name, 32'(out4), 32'(vecs[i].exp_out));
`ifdef AY_ENV_MULTI_DONE_EN
      if (i == 0) check("reset_done", 32'(done4), 32'd0);
`endif
    end

    // Triangle on ch2 with period 0 (acts as 1): one step per tick.
    do_reset();
    do_write(3'd2, 4'b1110, 16'd0, 1'b0);
    check("tri_k0", 32'(out4), 32'h000);
    for (int k = 1; k <= 40; k++) begin
      ticks(1);
      tri_exp = ((k % 30) <= 15) ? (k % 30) : (30 - (k % 30));
      check($sformatf("tri_k%0d", k), 32'(out4), 32'(tri_exp << 8));
    end

    // Continuous hold shapes, period 7: 16 steps then park.
    do_reset();
    do_write(3'd0, 4'b1011, 16'd7, 1'b0);
    do_write(3'd1, 4'b1101, 16'd7, 1'b0);
    do_write(3'd2, 4'b1111, 16'd7, 1'b0);
    check("hold_load", 32'(out4), 32'h00F);
    ticks(111);
    check("hold_step15", 32'(out4), 32'hFF0);
`ifdef AY_ENV_MULTI_DONE_EN
    check("hold_done_early", 32'(done4), 32'd0);
`endif
    ticks(1);
    check("hold_step16", 32'(out4), 32'h0FF);
`ifdef AY_ENV_MULTI_DONE_EN
    check("hold_done_pulse", 32'(done4), 32'b111);
    cyc();
    check("hold_done_clear", 32'(done4), 32'd0);
`endif
    ticks(50);
    check("hold_frozen", 32'(out4), 32'h0FF);
    do_write(3'd2, 4'b1001, 16'd7, 1'b0);
    check("hold1001_load", 32'(out4), 32'hFFF);
    ticks(111);
    check("hold1001_step15", 32'(out4), 32'h0FF);
    ticks(1);
    check("hold1001_step16", 32'(out4), 32'h0FF);
`ifdef AY_ENV_MULTI_DONE_EN
    check("hold1001_done", 32'(done4), 32'b100);
`endif
    ticks(30);
    check("hold1001_frozen", 32'(out4), 32'h0FF);

    // OUT_W=5: ramps on ch0 (period 2) and ch1 (period 1), then write+tick.
    do_reset();
    do_write(3'd1, 4'b1100, 16'd1, 1'b0);
    do_write(3'd0, 4'b1100, 16'd2, 1'b0);
    check("ym_load", 32'(out5), 32'd0);
    for (int t = 1; t <= 74; t++) begin
      ticks(1);
      if (t == 1 || t == 2 || t == 62 || t == 63 || t == 64 || t == 74) begin
        lvl0 = (t / 2) % 32;
        lvl1 = t % 32;
        check($sformatf("ym_t%0d", t), 32'(out5), 32'((lvl1 << 5) | lvl0));
      end
    end
    do_write(3'd0, 4'b1100, 16'd2, 1'b1);
    check("ym_wr_tick", 32'(out5), 32'((11 << 5) | 0));
    ticks(1);
    check("ym_after_wr_t1", 32'(out5), 32'((12 << 5) | 0));
    ticks(1);
    check("ym_after_wr_t2", 32'(out5), 32'((13 << 5) | 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
